// File: rtl/mem_arbiter.sv
// N-master to 1-slave arbiter for the valid/ready memory bus, with fixed-priority or
// round-robin selection and an optional per-transaction timeout that returns an error.
module mem_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT     = 0,
  localparam int GID_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  localparam int STRB_W = DATA_WIDTH / 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            m_valid,
  input  logic [NUM_MASTERS-1:0]            m_instr,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  input  logic [NUM_MASTERS*STRB_W-1:0]     m_wstrb,
  output logic [NUM_MASTERS-1:0]            m_ready,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
  output logic [NUM_MASTERS-1:0]            m_error,
  output logic                              s_valid,
  output logic                              s_instr,
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  output logic [STRB_W-1:0]                 s_wstrb,
  input  logic [DATA_WIDTH-1:0]             s_rdata,
  input  logic                              s_ready,
  output logic                              busy,
  output logic [GID_W-1:0]                  grant_id
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state_q, state_d;
  logic [GID_W-1:0]        gid_q, gid_d;
  logic [GID_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;

  logic [15:0]             vld_ext;
  logic [15:0]             instr_ext;
  logic [3:0]              win_sel;
  logic                    any_req;
  logic                    in_busy;
  logic                    tmo_hit;
  logic                    abort;
  logic                    done;
  logic [NUM_MASTERS-1:0]  gid_oh;

  // Rotating search: start at the pointer in round-robin mode, at 0 in fixed mode.
  always_comb begin
    logic found;
    int   idx;
    vld_ext   = 16'(m_valid);
    instr_ext = 16'(m_instr);
    any_req   = |m_valid;
    win_sel   = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = i;
      if (ARB_MODE == 1) idx = i + int'(ptr_q);
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && vld_ext[4'(idx)]) begin
        found   = 1'b1;
        win_sel = 4'(idx);
      end
    end
  end

  assign in_busy = (state_q == BUSY);
  // s_ready in the timeout cycle still completes the transfer normally.
  assign tmo_hit = (TIMEOUT > 0) && in_busy && (cnt_q == CNT_W'(TIMEOUT));
  assign done    = in_busy && s_ready;
  assign abort   = tmo_hit && !s_ready;
  assign gid_oh  = NUM_MASTERS'(1) << gid_q;

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (any_req) begin
          state_d = BUSY;
          gid_d   = GID_W'(win_sel);
          instr_d = instr_ext[win_sel];
          addr_d  = m_addr[int'(win_sel)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = m_wdata[int'(win_sel)*DATA_WIDTH +: DATA_WIDTH];
          wstrb_d = m_wstrb[int'(win_sel)*STRB_W +: STRB_W];
        end
      end
      BUSY: begin
        if (done || abort) begin
          state_d = IDLE;
          if (int'(gid_q) == NUM_MASTERS - 1) ptr_d = '0;
          else                                ptr_d = gid_q + 1'b1;
        end else if (TIMEOUT > 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = in_busy;
    grant_id = gid_q;
    s_valid  = in_busy && !tmo_hit;
    s_instr  = in_busy ? instr_q : 1'b0;
    s_addr   = in_busy ? addr_q  : '0;
    s_wdata  = in_busy ? wdata_q : '0;
    s_wstrb  = in_busy ? wstrb_q : '0;
    m_ready  = (done || abort) ? gid_oh : '0;
    m_error  = abort ? gid_oh : '0;
    m_rdata  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (done && gid_oh[i]) m_rdata[i*DATA_WIDTH +: DATA_WIDTH] = s_rdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gid_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request payload is only observed through the busy-gated outputs, so it needs no reset.
  always_ff @(posedge clock) begin
    instr_q <= instr_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 2-master fixed-priority instance with timeout and a
// 4-master round-robin instance without timeout.
module tb_mem_arbiter;

  logic clk;
  logic reset;

  // Instance A: NUM_MASTERS=2, fixed priority, TIMEOUT=5
  logic [1:0]  m_valid_a, m_instr_a, m_ready_a, m_error_a;
  logic [63:0] m_addr_a, m_wdata_a, m_rdata_a;
  logic [7:0]  m_wstrb_a;
  logic        s_valid_a, s_instr_a, s_ready_a, busy_a;
  logic [31:0] s_addr_a, s_wdata_a, s_rdata_a;
  logic [3:0]  s_wstrb_a;
  logic [0:0]  grant_id_a;

  // Instance B: NUM_MASTERS=4, round-robin, no timeout
  logic [3:0]   m_valid_b, m_instr_b, m_ready_b, m_error_b;
  logic [127:0] m_addr_b, m_wdata_b, m_rdata_b;
  logic [15:0]  m_wstrb_b;
  logic         s_valid_b, s_instr_b, s_ready_b, busy_b;
  logic [31:0]  s_addr_b, s_wdata_b, s_rdata_b;
  logic [3:0]   s_wstrb_b;
  logic [1:0]   grant_id_b;

  int n_vec = 0;
  int n_bad = 0;

  mem_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(0), .TIMEOUT(5)) dut_a (
    .clock(clk), .reset(reset),
    .m_valid(m_valid_a), .m_instr(m_instr_a), .m_addr(m_addr_a), .m_wdata(m_wdata_a),
    .m_wstrb(m_wstrb_a), .m_ready(m_ready_a), .m_rdata(m_rdata_a), .m_error(m_error_a),
    .s_valid(s_valid_a), .s_instr(s_instr_a), .s_addr(s_addr_a), .s_wdata(s_wdata_a),
    .s_wstrb(s_wstrb_a), .s_rdata(s_rdata_a), .s_ready(s_ready_a),
    .busy(busy_a), .grant_id(grant_id_a)
  );

  mem_arbiter #(.NUM_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ARB_MODE(1), .TIMEOUT(0)) dut_b (
    .clock(clk), .reset(reset),
    .m_valid(m_valid_b), .m_instr(m_instr_b), .m_addr(m_addr_b), .m_wdata(m_wdata_b),
    .m_wstrb(m_wstrb_b), .m_ready(m_ready_b), .m_rdata(m_rdata_b), .m_error(m_error_b),
    .s_valid(s_valid_b), .s_instr(s_instr_b), .s_addr(s_addr_b), .s_wdata(s_wdata_b),
    .s_wstrb(s_wstrb_b), .s_rdata(s_rdata_b), .s_ready(s_ready_b),
    .busy(busy_b), .grant_id(grant_id_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  vld;
    logic        rdy;
    logic [31:0] rdata;
    logic        exp_sv;
    logic [31:0] exp_addr;
    logic [1:0]  exp_mrdy;
    logic [63:0] exp_mrdata;
    logic        exp_gid;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{2'b11, 1'b0, 32'h0,        1'b0, 32'h0,  2'b00, 64'h0,                  1'b0};
    tbl[1] = '{2'b11, 1'b0, 32'h0,        1'b1, 32'h10, 2'b00, 64'h0,                  1'b0};
    tbl[2] = '{2'b11, 1'b1, 32'hDEADBEEF, 1'b1, 32'h10, 2'b01, 64'h00000000_DEADBEEF,  1'b0};
    tbl[3] = '{2'b10, 1'b0, 32'h0,        1'b0, 32'h0,  2'b00, 64'h0,                  1'b0};
    tbl[4] = '{2'b10, 1'b0, 32'h0,        1'b1, 32'h20, 2'b00, 64'h0,                  1'b1};
    tbl[5] = '{2'b10, 1'b1, 32'hCAFEF00D, 1'b1, 32'h20, 2'b10, 64'hCAFEF00D_00000000,  1'b1};
    tbl[6] = '{2'b00, 1'b0, 32'h0,        1'b0, 32'h0,  2'b00, 64'h0,                  1'b1};

    reset = 1'b1;
    m_valid_a = '0; m_instr_a = '0; m_addr_a = '0; m_wdata_a = '0; m_wstrb_a = '0;
    s_ready_a = 1'b0; s_rdata_a = '0;
    m_valid_b = '0; m_instr_b = '0; m_addr_b = '0; m_wdata_b = '0; m_wstrb_b = '0;
    s_ready_b = 1'b0; s_rdata_b = '0;
    for (int i = 0; i < 4; i++) m_addr_b[i*32 +: 32] = 32'h1000 + i;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst s_valid_a", 64'(s_valid_a), 64'h0);
    chk("rst busy_a", 64'(busy_a), 64'h0);
    chk("rst grant_a", 64'(grant_id_a), 64'h0);
    chk("rst s_addr_a", 64'(s_addr_a), 64'h0);
    chk("rst s_wdata_a", 64'({s_instr_a, s_wstrb_a, s_wdata_a}), 64'h0);
    chk("rst m_ready/err_a", 64'({m_ready_a, m_error_a}), 64'h0);
    chk("rst m_rdata_a", m_rdata_a, 64'h0);
    chk("rst s_valid_b", 64'({s_valid_b, busy_b, grant_id_b}), 64'h0);

    // Reset asserted mid-transaction
    @(negedge clk);
    reset = 1'b0;
    m_valid_a = 2'b01;
    m_addr_a[31:0] = 32'h100;
    #1 chk("rmb idle s_valid", 64'(s_valid_a), 64'h0);
    @(negedge clk); #1;
    chk("rmb s_valid", 64'(s_valid_a), 64'h1);
    chk("rmb s_addr", 64'(s_addr_a), 64'h100);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rmb rst s_valid", 64'(s_valid_a), 64'h0);
    chk("rmb rst busy", 64'(busy_a), 64'h0);
    chk("rmb rst m_ready", 64'(m_ready_a), 64'h0);
    chk("rmb rst s_addr", 64'(s_addr_a), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rmb rel s_valid", 64'(s_valid_a), 64'h0);
    @(negedge clk); #1;
    chk("rmb regrant s_valid", 64'(s_valid_a), 64'h1);
    chk("rmb regrant s_addr", 64'(s_addr_a), 64'h100);
    chk("rmb regrant gid", 64'(grant_id_a), 64'h0);
    s_ready_a = 1'b1; s_rdata_a = 32'h11;
    #1 chk("rmb m_ready", 64'(m_ready_a), 64'h1);
    @(negedge clk);
    s_ready_a = 1'b0; s_rdata_a = '0; m_valid_a = '0;

    // Fixed-priority vectors
    @(negedge clk);
    m_addr_a = {32'h20, 32'h10};
    for (int i = 0; i < 7; i++) begin
      m_valid_a = tbl[i].vld;
      s_ready_a = tbl[i].rdy;
      s_rdata_a = tbl[i].rdata;
      #1;
      chk($sformatf("fixed[%0d] s_valid", i), 64'(s_valid_a), 64'(tbl[i].exp_sv));
      if (tbl[i].exp_sv) chk($sformatf("fixed[%0d] s_addr", i), 64'(s_addr_a), 64'(tbl[i].exp_addr));
      chk($sformatf("fixed[%0d] m_ready", i), 64'(m_ready_a), 64'(tbl[i].exp_mrdy));
      chk($sformatf("fixed[%0d] m_rdata", i), m_rdata_a, tbl[i].exp_mrdata);
      chk($sformatf("fixed[%0d] grant", i), 64'(grant_id_a), 64'(tbl[i].exp_gid));
      @(negedge clk);
    end
    s_ready_a = 1'b0; s_rdata_a = '0;

    // Timeout, slave never ready
    m_valid_a = 2'b01; m_addr_a[31:0] = 32'h40; s_rdata_a = 32'h55555555;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      chk($sformatf("tmo1 wait%0d s_valid", k), 64'(s_valid_a), 64'h1);
      chk($sformatf("tmo1 wait%0d rdy/err", k), 64'({m_ready_a, m_error_a}), 64'h0);
    end
    @(negedge clk); #1;
    chk("tmo1 s_valid", 64'(s_valid_a), 64'h0);
    chk("tmo1 m_ready", 64'(m_ready_a), 64'h1);
    chk("tmo1 m_error", 64'(m_error_a), 64'h1);
    chk("tmo1 m_rdata", m_rdata_a, 64'h0);
    @(negedge clk);
    m_valid_a = '0;
    #1;
    chk("tmo1 after rdy/err", 64'({m_ready_a, m_error_a}), 64'h0);
    chk("tmo1 after busy", 64'(busy_a), 64'h0);

    // Timeout cycle coincides with s_ready
    m_valid_a = 2'b10; m_addr_a[63:32] = 32'h44; m_instr_a = 2'b10;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      chk($sformatf("tmo2 wait%0d rdy", k), 64'(m_ready_a), 64'h0);
      if (k == 1) chk("tmo2 s_instr", 64'(s_instr_a), 64'h1);
    end
    @(negedge clk);
    s_ready_a = 1'b1; s_rdata_a = 32'hA5A5A5A5;
    #1;
    chk("tmo2 m_ready", 64'(m_ready_a), 64'h2);
    chk("tmo2 m_error", 64'(m_error_a), 64'h0);
    chk("tmo2 m_rdata", m_rdata_a, 64'hA5A5A5A5_00000000);
    @(negedge clk);
    s_ready_a = 1'b0; s_rdata_a = '0; m_valid_a = '0; m_instr_a = '0;
    #1 chk("tmo2 after busy", 64'(busy_a), 64'h0);

    // Write payload held stable while the master changes its inputs
    m_valid_a = 2'b10; m_addr_a[63:32] = 32'h80; m_wdata_a[63:32] = 32'h1234; m_wstrb_a[7:4] = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (k == 0) begin
        m_wdata_a[63:32] = 32'hFFFF; m_wstrb_a[7:4] = 4'b1100;
        m_addr_a[63:32] = 32'h99; m_instr_a = 2'b10;
      end
      #1;
      chk($sformatf("wr%0d s_wdata", k), 64'(s_wdata_a), 64'h1234);
      chk($sformatf("wr%0d s_wstrb", k), 64'(s_wstrb_a), 64'h3);
      chk($sformatf("wr%0d s_addr", k), 64'(s_addr_a), 64'h80);
      chk($sformatf("wr%0d s_instr", k), 64'(s_instr_a), 64'h0);
    end
    @(negedge clk);
    s_ready_a = 1'b1;
    #1;
    chk("wr done s_wdata", 64'(s_wdata_a), 64'h1234);
    chk("wr done s_wstrb", 64'(s_wstrb_a), 64'h3);
    chk("wr done m_ready", 64'(m_ready_a), 64'h2);
    @(negedge clk);
    s_ready_a = 1'b0; m_valid_a = '0; m_instr_a = '0; m_wstrb_a = '0; m_wdata_a = '0;

    // Round-robin fairness, then wrap-around from last grant 3 with 4'b0110
    m_valid_b = 4'b1111;
    for (int t = 0; t < 9; t++) begin
      logic [1:0] exp_g;
      exp_g = (t < 8) ? 2'(t % 4) : 2'd1;
      if (t == 8) m_valid_b = 4'b0110;
      s_ready_b = 1'b0;
      @(negedge clk); #1;
      chk($sformatf("rr%0d grant", t), 64'(grant_id_b), 64'(exp_g));
      chk($sformatf("rr%0d s_addr", t), 64'(s_addr_b), 64'h1000 + 64'(exp_g));
      s_ready_b = 1'b1; s_rdata_b = 32'hB0 + 32'(t);
      #1 chk($sformatf("rr%0d m_ready", t), 64'(m_ready_b), 64'(4'b0001 << exp_g));
      @(negedge clk);
    end
    s_ready_b = 1'b0; m_valid_b = '0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised N-master to 1-slave arbiter for the core's valid/ready memory bus (valid, instr, addr, wdata, wstrb / rdata, ready).
- Merges the fetchbuffer instruction port, the data port and future masters (debug, DMA) onto one shared memory port.
- Supports fixed-priority or round-robin arbitration and an optional per-transaction timeout with an error response, which the current two-port top does not provide.

Parameters:
NUM_MASTERS, 2, number of requesting masters (1..16); index 0 is highest priority in fixed mode
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; wstrb width is DATA_WIDTH/8
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
TIMEOUT, 0, cycles to wait for s_ready before aborting; 0 disables the timeout

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
m_valid  input  NUM_MASTERS  per-master request valid
m_instr  input  NUM_MASTERS  per-master instruction-fetch flag
m_addr  input  NUM_MASTERS*ADDR_WIDTH  flattened addresses; master i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH]
m_wdata  input  NUM_MASTERS*DATA_WIDTH  flattened write data
m_wstrb  input  NUM_MASTERS*DATA_WIDTH/8  flattened byte strobes; all zero means read
m_ready  output  NUM_MASTERS  per-master completion pulse
m_rdata  output  NUM_MASTERS*DATA_WIDTH  flattened read data, valid with m_ready
m_error  output  NUM_MASTERS  timeout abort flag, pulses together with m_ready
s_valid  output  1  slave request valid
s_instr  output  1  slave instruction flag
s_addr  output  ADDR_WIDTH  slave address
s_wdata  output  DATA_WIDTH  slave write data
s_wstrb  output  DATA_WIDTH/8  slave byte strobes
s_rdata  input  DATA_WIDTH  slave read data
s_ready  input  1  slave completion
busy  output  1  a transaction is in flight
grant_id  output  clog2(NUM_MASTERS), min 1  index of the current or last granted master

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All outputs are 0: s_valid, s_instr, s_addr, s_wdata, s_wstrb, m_ready, m_rdata, m_error, busy, grant_id.
  - The round-robin pointer is reset to 0.
- Reset asserted mid-transaction drops s_valid immediately. No m_ready is issued for the aborted request.
- IDLE:
  - If any m_valid bit is set, choose the winner, latch its instr/addr/wdata/wstrb into internal registers, set grant_id, and go to BUSY.
  - Timeout counter is cleared.
  - Otherwise stay in IDLE; s_valid = 0.
- Arbitration:
  - Fixed mode: the lowest set index wins.
  - Round-robin mode: search upward from (last_grant+1) mod NUM_MASTERS with wrap-around; the first set index wins.
  - The round-robin pointer updates only when a transaction completes (normally or by timeout).
- BUSY:
  - s_valid = 1 and s_* are driven from the latched registers. They are stable for the whole transaction even if the master changes its inputs.
  - busy = 1.
- Completion: s_ready = 1 while in BUSY.
  - m_ready[grant_id] = 1 and m_rdata slice[grant_id] = s_rdata in the same cycle (combinational path from s_ready).
  - Next state is IDLE.
  - All other m_ready bits, m_rdata slices and m_error bits are 0.
- Timeout (TIMEOUT > 0): the counter increments each BUSY cycle without s_ready.
  - When the count reaches TIMEOUT, drive s_valid = 0, pulse m_ready[grant_id] and m_error[grant_id] for one cycle with rdata = 0, and go to IDLE.
  - If s_ready arrives in the same cycle as the timeout, s_ready wins: normal completion, m_error = 0.
- Latency:
  - s_valid rises 1 cycle after m_valid is sampled in IDLE.
  - Minimum request-to-m_ready time is 2 cycles (slave ready in its first valid cycle).
  - After each completion the arbiter spends one IDLE cycle, so peak throughput is one transaction per 2 cycles.
- Master protocol: a master keeps m_valid high until it sees m_ready, then deasserts or presents a new request by the next edge. The arbiter never grants a master whose m_valid is low in the IDLE cycle.
- NUM_MASTERS = 1: the arbiter degenerates to a registered pass-through; grant_id is always 0.

Test Plan:
- Reset mid-BUSY: m_valid[0]=1 with addr 0x100, slave never ready, assert reset on cycle 3 -> s_valid=0 immediately; all outputs 0; after release, m_valid[0] held high -> re-granted and s_addr=0x100 one cycle later.
- Fixed priority, ARB_MODE=0, NUM_MASTERS=2: m_valid=2'b11, addr0=0x10, addr1=0x20, slave ready after 1 cycle -> s_addr order 0x10 then 0x20; m_ready[0] precedes m_ready[1]; m_rdata carries s_rdata=0xDEADBEEF to master 0 only.
- Round-robin fairness, NUM_MASTERS=4, ARB_MODE=1: all m_valid held high for 8 transactions -> grant_id sequence 0,1,2,3,0,1,2,3.
- Round-robin wrap-around: last grant 3, m_valid=4'b0110 -> grant_id=1.
- Timeout, TIMEOUT=5, slave never ready:
  - Case 1 -> m_ready[g] and m_error[g] pulse 5 cycles after s_valid rises; rdata=0; s_valid drops.
  - Case 2, s_ready on the timeout cycle -> m_error=0.
- Write stability: master 1 issues wstrb=4'b0011, wdata=0x1234, then changes its inputs while BUSY -> s_wdata and s_wstrb stay 0x1234 / 4'b0011 until s_ready.
